// File: rtl/gomoku_pkg.sv
// Shared types, board geometry and scan-direction table for the gomoku board controller.
// Also holds the coordinate helpers used by the controller and the win checker.
package gomoku_pkg;

   localparam int BOARD_N      = 6;
   localparam int BOARD_CELLS  = BOARD_N * BOARD_N;
   localparam int WIN_LEN      = 5;
   localparam int BLINK_FRAMES = 15;
   localparam int ADDR_W       = 6;
   localparam int COORD_W      = 3;

   localparam logic [COORD_W-1:0] COORD_MAX   = COORD_W'(BOARD_N - 1);
   localparam logic [COORD_W-1:0] COORD_START = 3'd2;

   typedef enum logic [1:0] {
      CELL_EMPTY  = 2'b00,
      CELL_BLACK  = 2'b01,
      CELL_WHITE  = 2'b10,
      CELL_CURSOR = 2'b11
   } cell_t;

   typedef enum logic [2:0] {
      WC_IDLE,
      WC_SCAN_POS,
      WC_SCAN_NEG,
      WC_NEXT_DIR,
      WC_RESOLVE
   } wc_state_t;

   // Scan order: horizontal, vertical, diagonal, anti-diagonal.
   localparam logic signed [1:0] DIR_DROW [4] = '{2'sd0, 2'sd1, 2'sd1, 2'sd1};
   localparam logic signed [1:0] DIR_DCOL [4] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] row,
                                                  input logic [COORD_W-1:0] col);
      return ADDR_W'(row) * ADDR_W'(BOARD_N) + ADDR_W'(col);
   endfunction

   // Coordinate k steps from base along d; flip walks the opposite way.
   function automatic logic signed [4:0] step_coord(input logic [COORD_W-1:0] base,
                                                    input logic signed [1:0] d,
                                                    input logic [2:0] k,
                                                    input logic flip);
      logic signed [4:0] b;
      logic signed [4:0] kk;
      b  = $signed({2'b00, base});
      kk = $signed({2'b00, k});
      if (d == 2'sd0)
         return b;
      else if ((d == 2'sd1) != flip)
         return b + kk;
      else
         return b - kk;
   endfunction

endpackage

// File: rtl/gomoku_win_checker.sv
// Sequential five-in-a-row check around the most recently placed stone.
// Walks each direction outward one cell per cycle through a single cell read port.
module gomoku_win_checker
   import gomoku_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               abort,
   input  logic               start,
   input  logic [COORD_W-1:0] origin_row,
   input  logic [COORD_W-1:0] origin_col,
   input  cell_t              colour,
   output logic [ADDR_W-1:0]  rd_addr,
   input  cell_t              rd_data,
   output logic               busy,
   output logic               done,
   output logic               win
);

   localparam logic [2:0]        SCAN_LAST = 3'(WIN_LEN - 2);
   localparam logic signed [4:0] EDGE      = 5'(BOARD_N);

   wc_state_t          state_reg, state_next;
   logic [1:0]         dir_reg, dir_next;
   logic [2:0]         pos_reg, pos_next, neg_reg, neg_next;
   logic [COORD_W-1:0] row_reg, row_next, col_reg, col_next;
   cell_t              colour_reg, colour_next;
   logic               win_reg, win_next;

   logic              flip, in_board, match;
   logic [2:0]        step;
   logic signed [4:0] probe_row, probe_col;
   logic [3:0]        run;

   always_comb begin
      flip      = (state_reg == WC_SCAN_NEG);
      step      = (flip ? neg_reg : pos_reg) + 3'd1;
      probe_row = step_coord(row_reg, DIR_DROW[dir_reg], step, flip);
      probe_col = step_coord(col_reg, DIR_DCOL[dir_reg], step, flip);
      in_board  = (probe_row >= 5'sd0) && (probe_row < EDGE) &&
                  (probe_col >= 5'sd0) && (probe_col < EDGE);
      rd_addr   = in_board ? cell_addr(probe_row[2:0], probe_col[2:0]) : '0;
      match     = in_board && (rd_data == colour_reg);
      run       = 4'd1 + {1'b0, pos_reg} + {1'b0, neg_reg};
   end

   always_comb begin
      state_next  = state_reg;
      dir_next    = dir_reg;
      pos_next    = pos_reg;
      neg_next    = neg_reg;
      row_next    = row_reg;
      col_next    = col_reg;
      colour_next = colour_reg;
      win_next    = win_reg;
      case (state_reg)
         WC_IDLE: begin
            if (start) begin
               state_next  = WC_SCAN_POS;
               dir_next    = '0;
               pos_next    = '0;
               neg_next    = '0;
               row_next    = origin_row;
               col_next    = origin_col;
               colour_next = colour;
               win_next    = 1'b0;
            end
         end
         WC_SCAN_POS: begin
            if (match)
               pos_next = pos_reg + 3'd1;
            if (!match || pos_reg == SCAN_LAST)
               state_next = WC_SCAN_NEG;
         end
         WC_SCAN_NEG: begin
            if (match)
               neg_next = neg_reg + 3'd1;
            if (!match || neg_reg == SCAN_LAST)
               state_next = WC_NEXT_DIR;
         end
         WC_NEXT_DIR: begin
            if (run >= 4'(WIN_LEN)) begin
               win_next   = 1'b1;
               state_next = WC_RESOLVE;
            end else if (dir_reg == 2'd3) begin
               state_next = WC_RESOLVE;
            end else begin
               dir_next   = dir_reg + 2'd1;
               pos_next   = '0;
               neg_next   = '0;
               state_next = WC_SCAN_POS;
            end
         end
         WC_RESOLVE: state_next = WC_IDLE;
         default:    state_next = WC_IDLE;
      endcase
      if (abort)
         state_next = WC_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= WC_IDLE;
         dir_reg    <= '0;
         pos_reg    <= '0;
         neg_reg    <= '0;
         row_reg    <= '0;
         col_reg    <= '0;
         colour_reg <= CELL_EMPTY;
         win_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         dir_reg    <= dir_next;
         pos_reg    <= pos_next;
         neg_reg    <= neg_next;
         row_reg    <= row_next;
         col_reg    <= col_next;
         colour_reg <= colour_next;
         win_reg    <= win_next;
      end
   end

   assign busy = (state_reg != WC_IDLE);
   assign done = (state_reg == WC_RESOLVE);
   assign win  = win_reg;

endmodule

// File: rtl/gomoku_board_ctrl.sv
// Game-state owner for the VGA gomoku display: board storage, cursor, turn, blink and outcome.
// board[] is the stored cells with a blinking cursor overlay derived only from registered state.
module gomoku_board_ctrl
   import gomoku_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     btn_up,
   input  logic                     btn_down,
   input  logic                     btn_left,
   input  logic                     btn_right,
   input  logic                     btn_place,
   input  logic                     btn_new,
   input  logic                     frame_tick,
   output logic [2*BOARD_CELLS-1:0] board,
   output logic [COORD_W-1:0]       cursor_row,
   output logic [COORD_W-1:0]       cursor_col,
   output logic                     turn,
   output logic                     busy,
   output logic                     game_over,
   output logic [1:0]               winner
);

   cell_t              cells_reg [BOARD_CELLS];
   logic [COORD_W-1:0] row_reg, row_next, col_reg, col_next;
   logic               turn_reg, over_reg, blink_on_reg;
   logic [1:0]         winner_reg;
   logic [ADDR_W-1:0]  count_reg;
   logic [3:0]         blink_cnt_reg;

   logic [ADDR_W-1:0] cur_addr, rd_addr;
   cell_t             cur_cell, turn_colour, rd_data;
   logic              place_ok, move_en, chk_busy, chk_done, chk_win, show_cursor;

   assign cur_addr    = cell_addr(row_reg, col_reg);
   assign cur_cell    = cells_reg[cur_addr];
   assign rd_data     = cells_reg[rd_addr];
   assign turn_colour = turn_reg ? CELL_WHITE : CELL_BLACK;
   assign place_ok    = btn_place && !btn_new && !chk_busy && !over_reg && (cur_cell == CELL_EMPTY);
   assign move_en     = !btn_new && !btn_place && !chk_busy;

   // Opposing pulses cancel on their axis; edges saturate.
   always_comb begin
      row_next = row_reg;
      col_next = col_reg;
      if (move_en) begin
         if (btn_up && !btn_down && row_reg != '0)
            row_next = row_reg - 3'd1;
         else if (btn_down && !btn_up && row_reg != COORD_MAX)
            row_next = row_reg + 3'd1;
         if (btn_left && !btn_right && col_reg != '0)
            col_next = col_reg - 3'd1;
         else if (btn_right && !btn_left && col_reg != COORD_MAX)
            col_next = col_reg + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || btn_new) begin
         for (int i = 0; i < BOARD_CELLS; i++)
            cells_reg[i] <= CELL_EMPTY;
         row_reg       <= COORD_START;
         col_reg       <= COORD_START;
         turn_reg      <= 1'b0;
         over_reg      <= 1'b0;
         winner_reg    <= 2'b00;
         count_reg     <= '0;
         blink_cnt_reg <= '0;
         blink_on_reg  <= 1'b1;
      end else begin
         row_reg <= row_next;
         col_reg <= col_next;
         if (place_ok) begin
            cells_reg[cur_addr] <= turn_colour;
            count_reg           <= count_reg + 1'b1;
         end
         // The turn is frozen while the checker runs, so it still names the mover here.
         if (chk_done) begin
            if (chk_win) begin
               over_reg   <= 1'b1;
               winner_reg <= turn_colour;
            end else if (count_reg == ADDR_W'(BOARD_CELLS)) begin
               over_reg   <= 1'b1;
               winner_reg <= 2'b00;
            end else begin
               turn_reg <= !turn_reg;
            end
         end
         if (frame_tick) begin
            if (blink_cnt_reg == 4'(BLINK_FRAMES - 1)) begin
               blink_cnt_reg <= '0;
               blink_on_reg  <= !blink_on_reg;
            end else begin
               blink_cnt_reg <= blink_cnt_reg + 4'd1;
            end
         end
      end
   end

   gomoku_win_checker u_checker (
      .clk        (clk),
      .rst        (rst),
      .abort      (btn_new),
      .start      (place_ok),
      .origin_row (row_reg),
      .origin_col (col_reg),
      .colour     (turn_colour),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (chk_busy),
      .done       (chk_done),
      .win        (chk_win)
   );

   assign show_cursor = blink_on_reg && !over_reg && (cur_cell == CELL_EMPTY);

   for (genvar gi = 0; gi < BOARD_CELLS; gi++) begin : g_cell
      assign board[2*gi +: 2] = (show_cursor && cur_addr == ADDR_W'(gi)) ? CELL_CURSOR : cells_reg[gi];
   end

   assign cursor_row = row_reg;
   assign cursor_col = col_reg;
   assign turn       = turn_reg;
   assign busy       = chk_busy;
   assign game_over  = over_reg;
   assign winner     = winner_reg;

endmodule

// File: tb/tb_gomoku_board_ctrl.sv
// Directed and randomized bench for gomoku_board_ctrl against a rule-level game model.
module tb_gomoku_board_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic        btn_place = 1'b0, btn_new = 1'b0, frame_tick = 1'b0;
   logic [71:0] board;
   logic [2:0]  cursor_row, cursor_col;
   logic        turn, busy, game_over;
   logic [1:0]  winner;

   int n_cmp = 0;
   int n_bad = 0;

   // Game model: cell codes 0 empty, 1 black, 2 white.
   int m_cell [6][6];
   int m_r, m_c, m_win, m_count, m_ticks;
   bit m_turn, m_over;

   always #5 clk = ~clk;

   gomoku_board_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_place  (btn_place),
      .btn_new    (btn_new),
      .frame_tick (frame_tick),
      .board      (board),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .turn       (turn),
      .busy       (busy),
      .game_over  (game_over),
      .winner     (winner)
   );

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            m_cell[r][c] = 0;
      m_r = 2; m_c = 2; m_turn = 0; m_over = 0; m_win = 0; m_count = 0; m_ticks = 0;
   endtask

   function automatic bit five_at(input int r, input int c);
      int dr [4] = '{0, 1, 1, 1};
      int dc [4] = '{1, 0, 1, -1};
      int len, rr, cc;
      for (int d = 0; d < 4; d++) begin
         len = 1;
         for (int s = -1; s <= 1; s += 2) begin
            rr = r + s * dr[d];
            cc = c + s * dc[d];
            while (rr >= 0 && rr < 6 && cc >= 0 && cc < 6 && m_cell[rr][cc] == m_cell[r][c]) begin
               len++;
               rr += s * dr[d];
               cc += s * dc[d];
            end
         end
         if (len >= 5) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [71:0] exp_board();
      logic [71:0] v;
      int code;
      bit phase_on;
      v = '0;
      phase_on = ((m_ticks / 15) % 2) == 0;
      for (int a = 0; a < 36; a++) begin
         code = m_cell[a / 6][a % 6];
         if (a == m_r * 6 + m_c && phase_on && !m_over && code == 0)
            code = 3;
         v[2*a +: 2] = 2'(code);
      end
      return v;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".row"},    72'(cursor_row), 72'(m_r));
      chk({tag, ".col"},    72'(cursor_col), 72'(m_c));
      chk({tag, ".turn"},   72'(turn),       72'(m_turn));
      chk({tag, ".over"},   72'(game_over),  72'(m_over));
      chk({tag, ".winner"}, 72'(winner),     72'(m_win));
      chk({tag, ".busy"},   72'(busy),       72'(0));
      chk({tag, ".board"},  board,           exp_board());
   endtask

   task automatic drive(input bit u, input bit d, input bit l, input bit r,
                        input bit p, input bit n, input bit t);
      @(negedge clk);
      btn_up = u; btn_down = d; btn_left = l; btn_right = r;
      btn_place = p; btn_new = n; frame_tick = t;
      @(posedge clk);
      #1;
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
      btn_place = 0; btn_new = 0; frame_tick = 0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      bit t;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         t = 1'($urandom_range(0, 1));
         drive(0, 0, 0, 0, 0, 0, t);
         if (t) m_ticks++;
         n++;
      end
      chk({tag, ".busy_len"}, 72'(busy === 1'b0 && n >= 1 && n <= 37), 72'(1));
   endtask

   task automatic act(input string tag, input bit u, input bit d, input bit l, input bit r,
                      input bit p, input bit n, input bit t);
      bit acc;
      acc = 0;
      drive(u, d, l, r, p, n, t);
      if (n) begin
         model_reset();
      end else begin
         if (t) m_ticks++;
         if (p) begin
            if (!m_over && m_cell[m_r][m_c] == 0) begin
               acc = 1;
               m_cell[m_r][m_c] = m_turn ? 2 : 1;
               m_count++;
               if (five_at(m_r, m_c)) begin
                  m_over = 1; m_win = m_cell[m_r][m_c];
               end else if (m_count == 36) begin
                  m_over = 1; m_win = 0;
               end else begin
                  m_turn = !m_turn;
               end
            end
         end else begin
            if (u && !d && m_r > 0) m_r--;
            else if (d && !u && m_r < 5) m_r++;
            if (l && !r && m_c > 0) m_c--;
            else if (r && !l && m_c < 5) m_c++;
         end
      end
      if (acc) begin
         chk({tag, ".busy_on"}, 72'(busy), 72'(1));
         chk({tag, ".placed"}, board, exp_board());
         wait_idle(tag);
      end
      check_all(tag);
   endtask

   task automatic goto(input int r, input int c);
      while (m_r != r || m_c != c)
         act("goto", m_r > r, m_r < r, m_c > c, m_c < c, 0, 0, 0);
   endtask

   task automatic place_at(input int r, input int c);
      goto(r, c);
      act("place", 0, 0, 0, 0, 1, 0, 0);
   endtask

   initial begin
      int seq [4][9];
      int blk [$];
      int wht [$];
      int j, tmp;

      seq[0] = '{0, 6, 1, 7, 2, 8, 3, 9, 4};
      seq[1] = '{0, 1, 7, 2, 14, 3, 21, 4, 28};
      seq[2] = '{5, 30, 10, 31, 15, 32, 20, 33, 25};
      seq[3] = '{0, 30, 1, 31, 3, 32, 4, 33, 2};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_all("reset");
      chk("reset.cursor_code", 72'(board[29:28]), 72'(2'b11));

      // Cursor moves and edge saturation.
      repeat (3) act("right", 0, 0, 0, 1, 0, 0, 0);
      act("up", 1, 0, 0, 0, 0, 0, 0);
      chk("move.row15", 72'(cursor_row), 72'(1));
      chk("move.col15", 72'(cursor_col), 72'(5));
      repeat (2) act("right_sat", 0, 0, 0, 1, 0, 0, 0);
      chk("sat.col", 72'(cursor_col), 72'(5));

      // First placement and rejected re-placement.
      place_at(2, 2);
      chk("first.cell14", 72'(board[29:28]), 72'(2'b01));
      chk("first.turn", 72'(turn), 72'(1));
      act("replace", 0, 0, 0, 0, 1, 0, 0);
      chk("replace.turn", 72'(turn), 72'(1));

      // Horizontal, diagonal, anti-diagonal and middle-filled wins for black.
      for (int g = 0; g < 4; g++) begin
         act("new", 0, 0, 0, 0, 0, 1, 0);
         for (int k = 0; k < 9; k++)
            place_at(seq[g][k] / 6, seq[g][k] % 6);
         chk("win.over", 72'(game_over), 72'(1));
         chk("win.winner", 72'(winner), 72'(2'b01));
         place_at(5, 5);
         chk("win.ignored", 72'(board[71:70]), 72'(2'b00));
      end

      // Full board with no five-in-a-row anywhere: draw.
      act("new", 0, 0, 0, 0, 0, 1, 0);
      for (int a = 0; a < 36; a++)
         if ((((a % 6) / 2 + a / 6) % 2) == 0) blk.push_back(a);
         else wht.push_back(a);
      for (int i = 17; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = blk[i]; blk[i] = blk[j]; blk[j] = tmp;
         j = $urandom_range(0, i);
         tmp = wht[i]; wht[i] = wht[j]; wht[j] = tmp;
      end
      for (int i = 0; i < 18; i++) begin
         place_at(blk[i] / 6, blk[i] % 6);
         place_at(wht[i] / 6, wht[i] % 6);
      end
      chk("draw.over", 72'(game_over), 72'(1));
      chk("draw.winner", 72'(winner), 72'(2'b00));

      // New game issued three cycles into a running check.
      act("new", 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("abort.busy1", 72'(busy), 72'(1));
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("abort.busy3", 72'(busy), 72'(1));
      act("abort", 0, 0, 0, 0, 0, 1, 0);
      chk("abort.empty", board, {36{2'b00}} | (72'(2'b11) << 28));

      // Blink on an empty cursor cell, then on a stone.
      for (int i = 0; i < 30; i++) begin
         act("blink", 0, 0, 0, 0, 0, 0, 1);
         if (i == 13) chk("blink.on14", 72'(board[29:28]), 72'(2'b11));
         if (i == 14) chk("blink.off15", 72'(board[29:28]), 72'(2'b00));
         if (i == 29) chk("blink.on30", 72'(board[29:28]), 72'(2'b11));
      end
      place_at(2, 2);
      for (int i = 0; i < 20; i++) begin
         act("blink_stone", 0, 0, 0, 0, 0, 0, 1);
         chk("blink.stone", 72'(board[29:28]), 72'(2'b01));
      end
      act("udl", 1, 1, 1, 0, 0, 0, 0);
      chk("udl.row", 72'(cursor_row), 72'(2));
      chk("udl.col", 72'(cursor_col), 72'(1));

      // Randomized play.
      act("rnd_new", 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 300; i++) begin
         if (m_over && $urandom_range(0, 3) == 0)
            act("rnd_new", 0, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)));
         else if ($urandom_range(0, 3) == 0)
            act("rnd_place", 0, 0, 0, 0, 1, 0, 1'($urandom_range(0, 1)));
         else
            act("rnd_move", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0,
                1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
